// File: rtl/puf_ctrl_pkg.sv
// Shared types and widths for the PUF key sequencer.
package puf_ctrl_pkg;

    localparam int unsigned RESP_W = 8;  // parallel PUF cells
    localparam int unsigned CHAL_W = 2;  // challenge bus width

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StGap,
        StVote,
        StDone
    } state_e;

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit ones counters for majority voting of PUF responses.
// Optional macro: PUF_STABILITY_EN adds per-bit unanimity (unstable) flags.
module puf_vote_acc
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLES = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    input  logic [RESP_W-1:0] resp,
    output logic [RESP_W-1:0] majority
`ifdef PUF_STABILITY_EN
    ,
    output logic [RESP_W-1:0] unstable
`endif
);

    localparam int unsigned CNT_W = $clog2(SAMPLES + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(SAMPLES / 2);
`ifdef PUF_STABILITY_EN
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SAMPLES);
`endif

    logic [CNT_W-1:0] cnt_q [RESP_W];

    // Count ones per response bit; clear wins over increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(RESP_W); i++) begin
            if (reset || clear) begin
                cnt_q[i] <= '0;
            end else if (inc && resp[i]) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Majority and (optionally) disagreement flags from the current counts.
    always_comb begin
        majority = '0;
`ifdef PUF_STABILITY_EN
        unstable = '0;
`endif
        for (int i = 0; i < int'(RESP_W); i++) begin
            majority[i] = cnt_q[i] > HALF;
`ifdef PUF_STABILITY_EN
            unstable[i] = (cnt_q[i] != '0) && (cnt_q[i] != FULL);
`endif
        end
    end

endmodule

// File: rtl/puf_key_ctrl.sv
// PUF key sequencer: sweeps challenges, samples each several times, majority-votes
// the responses into a key and hands it over with a valid/ack handshake.
// Optional macro: PUF_STABILITY_EN adds the unstable_mask output.
module puf_key_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLES       = 5,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_CHAL      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         puf_enable,
    output logic [CHAL_W-1:0]            puf_challenge,
    input  logic [RESP_W-1:0]            puf_response,
    output logic [RESP_W*NUM_CHAL-1:0]   key,
    output logic                         key_valid,
    input  logic                         key_ack
`ifdef PUF_STABILITY_EN
    ,
    output logic [RESP_W*NUM_CHAL-1:0]   unstable_mask
`endif
);

    localparam int unsigned KEY_W  = RESP_W * NUM_CHAL;
    localparam int unsigned SAMP_W = $clog2(SAMPLES + 1);
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);

    state_e              state_q, state_d;
    logic [SET_W-1:0]    settle_q;
    logic [SAMP_W-1:0]   samp_q;
    logic [CHAL_W-1:0]   chal_q;
    logic [KEY_W-1:0]    key_q;
    logic                acc_clear, acc_inc;
    logic                settle_last, samp_last, chal_last;
    logic [RESP_W-1:0]   majority;
`ifdef PUF_STABILITY_EN
    logic [RESP_W-1:0]   unstable;
    logic [KEY_W-1:0]    unstable_q;
`endif

    assign settle_last = settle_q == SET_W'(SETTLE_CYCLES - 1);
    assign samp_last   = samp_q == SAMP_W'(SAMPLES - 1);
    assign chal_last   = chal_q == CHAL_W'(NUM_CHAL - 1);

    puf_vote_acc #(
        .SAMPLES (SAMPLES)
    ) u_vote_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .inc      (acc_inc),
        .resp     (puf_response),
        .majority (majority)
`ifdef PUF_STABILITY_EN
        ,
        .unstable (unstable)
`endif
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and accumulator controls.
    always_comb begin
        state_d   = state_q;
        acc_clear = 1'b0;
        acc_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_clear = 1'b1;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                if (settle_last) begin
                    acc_inc = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = samp_last ? StVote : StSettle;
            end
            StVote: begin
                acc_clear = 1'b1;
                state_d   = chal_last ? StDone : StSettle;
            end
            StDone: begin
                // A simultaneous start is dropped on purpose.
                if (key_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Indices, key and stability mask bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_q <= '0;
            samp_q   <= '0;
            chal_q   <= '0;
            key_q    <= '0;
`ifdef PUF_STABILITY_EN
            unstable_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        settle_q <= '0;
                        samp_q   <= '0;
                        chal_q   <= '0;
                        key_q    <= '0;
`ifdef PUF_STABILITY_EN
                        unstable_q <= '0;
`endif
                    end
                end
                StSettle: begin
                    settle_q <= settle_last ? '0 : settle_q + SET_W'(1);
                end
                StGap: begin
                    if (!samp_last) begin
                        samp_q <= samp_q + SAMP_W'(1);
                    end
                end
                StVote: begin
                    key_q[int'(chal_q)*RESP_W +: RESP_W] <= majority;
`ifdef PUF_STABILITY_EN
                    unstable_q[int'(chal_q)*RESP_W +: RESP_W] <= unstable;
`endif
                    samp_q <= '0;
                    if (!chal_last) begin
                        chal_q <= chal_q + CHAL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and held registers.
    always_comb begin
        busy          = state_q != StIdle;
        puf_enable    = state_q == StSettle;
        puf_challenge = chal_q;
        key_valid     = state_q == StDone;
        key           = key_q;
`ifdef PUF_STABILITY_EN
        unstable_mask = unstable_q;
`endif
    end

endmodule

// File: tb/tb_puf_key_ctrl.sv
// Randomized self-checking bench for puf_key_ctrl against a table-driven vote model.
module tb_puf_key_ctrl;

    localparam int S  = 5;
    localparam int T  = 4;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset, start, key_ack;
    logic        busy, puf_enable, key_valid;
    logic [1:0]  puf_challenge;
    logic [7:0]  resp;
    logic [31:0] key;
`ifdef PUF_STABILITY_EN
    logic [31:0] unstable_mask;
`endif

    logic        s_reset, s_start, s_ack, s_busy, s_en, s_valid;
    logic [1:0]  s_chal;
    logic [7:0]  s_resp, s_key;
`ifdef PUF_STABILITY_EN
    logic [7:0]  s_unstable;
`endif

    logic [7:0]  tbl [NC][S];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    puf_key_ctrl u_dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .puf_enable    (puf_enable),
        .puf_challenge (puf_challenge),
        .puf_response  (resp),
        .key           (key),
        .key_valid     (key_valid),
        .key_ack       (key_ack)
`ifdef PUF_STABILITY_EN
        ,
        .unstable_mask (unstable_mask)
`endif
    );

    puf_key_ctrl #(
        .SAMPLES       (1),
        .SETTLE_CYCLES (1),
        .NUM_CHAL      (1)
    ) u_small (
        .clk           (clk),
        .reset         (s_reset),
        .start         (s_start),
        .busy          (s_busy),
        .puf_enable    (s_en),
        .puf_challenge (s_chal),
        .puf_response  (s_resp),
        .key           (s_key),
        .key_valid     (s_valid),
        .key_ack       (s_ack)
`ifdef PUF_STABILITY_EN
        ,
        .unstable_mask (s_unstable)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: majority and disagreement per bit, counted over the sample table.
    function automatic logic [31:0] model_key();
        logic [31:0] k = '0;
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 8; i++) begin
                int ones = 0;
                for (int s = 0; s < S; s++) ones += int'(tbl[c][s][i]);
                k[8*c+i] = ones > S / 2;
            end
        end
        return k;
    endfunction

    function automatic logic [31:0] model_unstable();
        logic [31:0] m = '0;
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 8; i++) begin
                int ones = 0;
                for (int s = 0; s < S; s++) ones += int'(tbl[c][s][i]);
                m[8*c+i] = (ones != 0) && (ones != S);
            end
        end
        return m;
    endfunction

    task automatic load_clean();
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < S; s++) tbl[c][s] = 8'hA5 ^ 8'(c);
    endtask

    // One key generation: drives responses per sample window, checks the enable
    // pattern each cycle and the key at the expected completion edge.
    task automatic run_key(input int pulse_a, input int pulse_b, input int reset_at,
                           output bit aborted);
        int cyc = 0;
        aborted = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < NC; c++) begin
            for (int s = 0; s < S; s++) begin
                resp = tbl[c][s];
                for (int k = 0; k <= T; k++) begin
                    @(negedge clk);
                    check_eq("puf_enable", 32'(puf_enable), 32'(k < T));
                    check_eq("puf_challenge", 32'(puf_challenge), 32'(c));
                    @(posedge clk); #1;
                    cyc++;
                    start = (cyc == pulse_a) || (cyc == pulse_b);
                    if (cyc == reset_at) begin
                        reset = 1'b1;
                        start = 1'b0;
                        @(posedge clk); #1;
                        reset = 1'b0;
                        check_eq("rst_enable", 32'(puf_enable), 32'd0);
                        check_eq("rst_busy", 32'(busy), 32'd0);
                        check_eq("rst_key", key, 32'd0);
                        check_eq("rst_valid", 32'(key_valid), 32'd0);
                        aborted = 1'b1;
                        return;
                    end
                end
            end
            @(negedge clk);
            check_eq("vote_enable", 32'(puf_enable), 32'd0);
            check_eq("early_valid", 32'(key_valid), 32'd0);
            @(posedge clk); #1;
            cyc++;
            start = (cyc == pulse_a) || (cyc == pulse_b);
        end
        start = 1'b0;
        @(negedge clk);
        check_eq("valid_latency", 32'(key_valid), 32'd1);
        check_eq("key", key, model_key());
`ifdef PUF_STABILITY_EN
        check_eq("unstable_mask", unstable_mask, model_unstable());
`endif
    endtask

    // Hold the key unacknowledged, then ack together with start.
    task automatic handshake(input int hold, input logic [31:0] exp_key);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(key_valid), 32'd1);
            check_eq("hold_key", key, exp_key);
        end
        key_ack = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        key_ack = 1'b0;
        start   = 1'b0;
        check_eq("ack_busy", 32'(busy), 32'd0);
        check_eq("ack_valid", 32'(key_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_restart", 32'(busy), 32'd0);
        check_eq("idle_key", key, exp_key);
    endtask

    initial begin
        bit ab;
        int n;
        logic [31:0] exp;
        reset = 1'b1; start = 1'b0; key_ack = 1'b0; resp = '0;
        s_reset = 1'b1; s_start = 1'b0; s_ack = 1'b0; s_resp = 8'hA5;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; s_reset = 1'b0;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_enable", 32'(puf_enable), 32'd0);
        check_eq("reset_chal", 32'(puf_challenge), 32'd0);
        check_eq("reset_key", key, 32'd0);
        check_eq("reset_valid", 32'(key_valid), 32'd0);

        // Noise-free sweep, then long hold and ack+start collision.
        load_clean();
        run_key(-1, -1, -1, ab);
        check_eq("clean_key", key, 32'hA6A7A4A5);
        handshake(50, 32'hA6A7A4A5);

        // Two minority flips on chal 1 bit 0: key unchanged, bit flagged.
        load_clean();
        tbl[1][0][0] = 1'b1; tbl[1][1][0] = 1'b1;
        run_key(-1, -1, -1, ab);
        check_eq("noise2_key", key, 32'hA6A7A4A5);
`ifdef PUF_STABILITY_EN
        check_eq("noise2_mask", unstable_mask, 32'h00000100);
`endif
        handshake(2, 32'hA6A7A4A5);

        // Three flips: majority changes.
        tbl[1][2][0] = 1'b1;
        run_key(-1, -1, -1, ab);
        check_eq("noise3_key", key, 32'hA6A7A5A5);
        handshake(2, 32'hA6A7A5A5);

        // start pulses while busy are ignored.
        load_clean();
        run_key(10, 60, -1, ab);
        handshake(1, 32'hA6A7A4A5);

        // Reset mid-run, then a clean run.
        run_key(-1, -1, 40, ab);
        check_eq("aborted", 32'(ab), 32'd1);
        run_key(-1, -1, -1, ab);
        check_eq("post_reset_key", key, 32'hA6A7A4A5);
        handshake(1, 32'hA6A7A4A5);

        // Randomized tables with sparse noise.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NC; c++) begin
                logic [7:0] base = 8'($urandom);
                for (int s = 0; s < S; s++)
                    tbl[c][s] = base ^ 8'($urandom & $urandom & $urandom);
            end
            exp = model_key();
            run_key(-1, -1, -1, ab);
            handshake($urandom_range(0, 5), exp);
        end

        // Minimal configuration: 1 sample, 1 settle cycle, 1 challenge.
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        n = 0;
        while (!s_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("small_latency", 32'(n), 32'd3);
        check_eq("small_key", {24'h0, s_key}, 32'h000000A5);
        s_ack = 1'b1;
        @(posedge clk); #1 s_ack = 1'b0;
        check_eq("small_idle", 32'(s_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
